// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 8-bit datapath: owns PC and IR, fetches
// over a req/ack handshake, and steps FETCH -> DECODE -> EXEC -> WB.
module multicycle_sequencer #(
    parameter int PC_W          = 4,
    parameter int CNT_W         = 16,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [7:0]       imem_data,
    output logic [7:0]       ir,
    output logic [2:0]       alu_op,
    output logic             rf_we,
    output logic [PC_W-1:0]  pc,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    logic       step_flag;
    logic [7:0] fetch_cnt;
    logic [2:0] alu_dec;

    always_comb begin
        alu_dec = 3'b000;
        case (ir[7:6])
            2'b00:   alu_dec = 3'b001;
            2'b01:   alu_dec = 3'b010;
            2'b10:   alu_dec = 3'b011;
            default: alu_dec = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            retire_cnt <= '0;
            alu_op     <= '0;
            step_flag  <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state     <= S_FETCH;
                        step_flag <= 1'b0;
                    end else if (step) begin
                        state     <= S_FETCH;
                        step_flag <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir        <= imem_data;
                        fetch_cnt <= '0;
                        state     <= S_DECODE;
                    end else if (fetch_cnt == TIMEOUT_LAST) begin
                        fetch_cnt <= '0;
                        state     <= S_FAULT;
                    end else begin
                        fetch_cnt <= fetch_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    alu_op <= alu_dec;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (ir[7:6] == 2'b11) begin
                        pc     <= '0;
                        alu_op <= '0;
                        if (retire_cnt != '1)
                            retire_cnt <= retire_cnt + 1'b1;
                        if (run && !step_flag) begin
                            state <= S_FETCH;
                        end else begin
                            state     <= S_IDLE;
                            step_flag <= 1'b0;
                        end
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    pc     <= pc + 1'b1;
                    alu_op <= '0;
                    if (retire_cnt != '1)
                        retire_cnt <= retire_cnt + 1'b1;
                    if (run && !step_flag) begin
                        state <= S_FETCH;
                    end else begin
                        state     <= S_IDLE;
                        step_flag <= 1'b0;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode from the state register only, so no input reaches an output.
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign rf_we     = (state == S_WB);
    assign halted    = (state == S_IDLE);
    assign fault     = (state == S_FAULT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: free-run, jump, single-step,
// fetch wait/timeout and reset-abort scenarios with hand-derived expectations.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_ack = 1'b1;
    logic [7:0]  imem_data;
    logic [7:0]  ir;
    logic [2:0]  alu_op;
    logic        rf_we;
    logic [3:0]  pc;
    logic [2:0]  state;
    logic        halted;
    logic        fault;
    logic [15:0] retire_cnt;

    logic [7:0]  mem [16];
    int          total = 0;
    int          bad = 0;
    int          we_cnt = 0;
    int          we_snap;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    always @(negedge clk) if (rf_we) we_cnt++;

    multicycle_sequencer #(
        .PC_W(4),
        .CNT_W(16),
        .FETCH_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .step(step),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_data(imem_data),
        .ir(ir),
        .alu_op(alu_op),
        .rf_we(rf_we),
        .pc(pc),
        .state(state),
        .halted(halted),
        .fault(fault),
        .retire_cnt(retire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int unsigned i = 0; i < 16; i++) mem[i] = 8'h01;
        mem[0] = 8'hAB;

        // Reset state
        do_reset();
        check("rst_state", 32'(state), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_ir", 32'(ir), 0);
        check("rst_retire", 32'(retire_cnt), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_req", 32'(imem_req), 0);
        check("rst_halted", 32'(halted), 1);

        // First instruction 0xAB (OR) with zero-wait ack
        run = 1'b1;
        tick();
        check("t1_fetch_state", 32'(state), 1);
        check("t1_fetch_req", 32'(imem_req), 1);
        check("t1_fetch_addr", 32'(imem_addr), 0);
        tick();
        check("t1_dec_state", 32'(state), 2);
        check("t1_ir", 32'(ir), 32'h AB);
        check("t1_dec_alu_op", 32'(alu_op), 0);
        tick();
        check("t1_exec_alu_op", 32'(alu_op), 3);
        check("t1_exec_rf_we", 32'(rf_we), 0);
        tick();
        check("t1_wb_state", 32'(state), 4);
        check("t1_wb_rf_we", 32'(rf_we), 1);
        check("t1_wb_alu_op", 32'(alu_op), 3);
        tick();
        check("t1_next_state", 32'(state), 1);
        check("t1_next_addr", 32'(imem_addr), 1);
        check("t1_pc", 32'(pc), 1);
        check("t1_retire", 32'(retire_cnt), 1);
        check("t1_next_alu_op", 32'(alu_op), 0);
        check("t1_next_rf_we", 32'(rf_we), 0);

        // Free-run 16 ALU instructions, pc wraps back to 0
        do_reset();
        we_snap = we_cnt;
        run = 1'b1;
        tick();
        repeat (64) tick();
        check("t2_retire", 32'(retire_cnt), 16);
        check("t2_pc_wrap", 32'(pc), 0);
        check("t2_we_pulses", 32'(we_cnt - we_snap), 16);
        check("t2_state", 32'(state), 1);

        // Jump 0xEF at pc=5
        for (int unsigned i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[5] = 8'hEF;
        do_reset();
        run = 1'b1;
        tick();
        repeat (20) tick();
        check("t3_fetch_addr", 32'(imem_addr), 5);
        we_snap = we_cnt;
        tick();
        check("t3_ir", 32'(ir), 32'h EF);
        tick();
        check("t3_exec_state", 32'(state), 3);
        check("t3_exec_alu_op", 32'(alu_op), 0);
        tick();
        check("t3_state", 32'(state), 1);
        check("t3_pc", 32'(pc), 0);
        check("t3_addr", 32'(imem_addr), 0);
        check("t3_retire", 32'(retire_cnt), 6);
        check("t3_no_we", 32'(we_cnt - we_snap), 0);

        // Single-step, with a step pulse during EXEC that must be ignored
        mem[0] = 8'h10;
        mem[1] = 8'h50;
        do_reset();
        step = 1'b1;
        tick();
        step = 1'b0;
        check("t4_fetch_state", 32'(state), 1);
        tick();
        tick();
        check("t4_exec_alu_op", 32'(alu_op), 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("t4_wb_state", 32'(state), 4);
        tick();
        check("t4_idle_state", 32'(state), 0);
        check("t4_halted", 32'(halted), 1);
        check("t4_pc", 32'(pc), 1);
        check("t4_retire", 32'(retire_cnt), 1);
        tick();
        check("t4_step_not_queued", 32'(state), 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("t4_step2_addr", 32'(imem_addr), 1);
        check("t4_step2_state", 32'(state), 1);
        tick();
        tick();
        check("t4_step2_alu_op", 32'(alu_op), 2);
        tick();
        tick();
        check("t4_step2_idle", 32'(state), 0);
        check("t4_step2_pc", 32'(pc), 2);
        check("t4_step2_retire", 32'(retire_cnt), 2);

        // Ack withheld three FETCH cycles, then fetch timeout into FAULT
        mem[0] = 8'h80;
        do_reset();
        imem_ack = 1'b0;
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("t5_wait_state", 32'(state), 1);
        check("t5_wait_ir", 32'(ir), 0);
        imem_ack = 1'b1;
        tick();
        check("t5_dec_state", 32'(state), 2);
        check("t5_ir", 32'(ir), 32'h80);
        tick();
        tick();
        tick();
        check("t5_7cyc_state", 32'(state), 1);
        check("t5_7cyc_pc", 32'(pc), 1);
        check("t5_7cyc_retire", 32'(retire_cnt), 1);
        imem_ack = 1'b0;
        repeat (14) tick();
        check("t5_pre_fault", 32'(state), 1);
        tick();
        check("t5_fault_state", 32'(state), 5);
        check("t5_fault_flag", 32'(fault), 1);
        run = 1'b1;
        step = 1'b1;
        imem_ack = 1'b1;
        repeat (5) tick();
        check("t5_sticky_state", 32'(state), 5);
        check("t5_sticky_req", 32'(imem_req), 0);
        check("t5_sticky_pc", 32'(pc), 1);
        check("t5_sticky_ir", 32'(ir), 32'h80);
        check("t5_sticky_alu_op", 32'(alu_op), 0);
        check("t5_sticky_rf_we", 32'(rf_we), 0);
        do_reset();
        check("t5_clear_fault", 32'(fault), 0);
        check("t5_clear_state", 32'(state), 0);

        // Reset asserted during WB aborts the instruction
        mem[0] = 8'h00;
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("t6_wb_rf_we", 32'(rf_we), 1);
        rst = 1'b1;
        tick();
        we_snap = we_cnt;
        check("t6_state", 32'(state), 0);
        check("t6_pc", 32'(pc), 0);
        check("t6_retire", 32'(retire_cnt), 0);
        check("t6_ir", 32'(ir), 0);
        check("t6_rf_we", 32'(rf_we), 0);
        check("t6_alu_op", 32'(alu_op), 0);
        check("t6_req", 32'(imem_req), 0);
        rst = 1'b0;
        run = 1'b0;
        tick();
        tick();
        check("t6_no_more_we", 32'(we_cnt - we_snap), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
